simple_axi_master: RTL and testbench
====================================

# simple_axi_master

AXI4-Lite single-outstanding master that converts a simple command/response interface into AXI4-Lite read and write transactions. It sits directly upstream of `Simple_AXI_RAM` and drives its five AXI channels, so a controller or test sequencer can access the RAM with one command per transaction. It handles one transaction at a time, drives address and data channels independently, and supports back-pressure on every channel.

## Interface
- `ADDR_WIDTH_BITS`, default 3: AXI address width; must match the slave's address width.
- `DATA_WIDTH_BYTES`, default 4: data width in bytes; `DATA_WIDTH_BITS = DATA_WIDTH_BYTES*8`.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_WIDTH_BITS  target address.
- `cmd_wdata`  in  DATA_WIDTH_BITS  write data; ignored for reads.
- `cmd_wstrb`  in  DATA_WIDTH_BYTES  byte strobes; ignored for reads.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed when `rsp_valid && rsp_ready`.
- `rsp_rdata`  out  DATA_WIDTH_BITS  read data; 0 for writes.
- `rsp_resp`  out  2  captured RRESP or BRESP.
- `err_count`  out  16  saturating count of non-OKAY responses.
- AXI master ports, named and sized as on the slave:
  - AR channel: `ARVALID`/`ARREADY`/`ARADDR`/`ARPROT`.
  - R channel: `RVALID`/`RREADY`/`RDATA`/`RRESP`.
  - AW channel: `AWVALID`/`AWREADY`/`AWADDR`/`AWPROT`.
  - W channel: `WVALID`/`WREADY`/`WDATA`/`WSTRB`.
  - B channel: `BVALID`/`BREADY`/`BRESP`.
  - `ARPROT` and `AWPROT` are tied to 0.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, RSP.
- **IDLE**
  - `cmd_ready` = 1 only in this state.
  - On accept, register addr/wdata/wstrb.
  - Write command → WR_REQ. Read command → RD_ADDR.
- **WR_REQ**
  - `AWVALID` and `WVALID` are both high on entry.
  - Each drops independently on its own handshake; the other stays high and keeps its payload stable.
  - Handshakes may complete in the same cycle or in either order.
  - When both have completed → WR_RESP.
- **WR_RESP**
  - `BREADY` = 1.
  - On `BVALID`: capture `BRESP` into `rsp_resp`, set `rsp_rdata` = 0 → RSP.
- **RD_ADDR**
  - `ARVALID` = 1, `ARADDR` held stable.
  - On `ARREADY` → RD_DATA.
- **RD_DATA**
  - `RREADY` = 1.
  - On `RVALID`: capture `RDATA` and `RRESP` → RSP.
- **RSP**
  - `rsp_valid` = 1; data and response held stable until `rsp_ready`, then → IDLE.
- Valid signals never drop before their handshake.
- Payload outputs are 0 whenever the matching valid is low.
- `err_count`:
  - Increments by 1 on entering RSP with `rsp_resp != 2'b00`.
  - Saturates at 0xFFFF; no wrap.
- Reset, in any state (including mid-transaction):
  - State returns to IDLE; all outputs are 0, including `err_count`.
  - The in-flight transaction is abandoned, and the slave must also be reset.

## Timing
- Reset values: every output 0. `cmd_ready` becomes 1 in the first cycle after `rst` deasserts.
- All AXI outputs and `rsp_*` outputs are registered; there is no combinational path from any input to any output except the state-derived `cmd_ready`.
- Command accepted at edge N: the valid signals (`AWVALID`/`WVALID`, or `ARVALID`) are high from cycle N+1.
- Zero-wait slave, write:
  - AW and W handshake at edge N+1.
  - `BREADY` high in cycle N+2; B handshake at edge N+2 if `BVALID` is already high.
  - `rsp_valid` high from N+3.
- Zero-wait slave, read:
  - AR handshake at edge N+1.
  - `RREADY` high in N+2; R handshake at edge N+2.
  - `rsp_valid` high from N+3.
- Each slave wait cycle on any channel adds exactly one cycle.
- Back-to-back: `rsp_ready` at edge M → `cmd_ready` high in cycle M+1. Throughput is at most one transaction per 4 cycles.

## Test plan
- Write then read, against `Simple_AXI_RAM` (NUM_SLOTS=5, RAM reset to 0):
  - Stimulus: write addr 4, data 0x11223344, wstrb 0b1101; then read addr 4.
  - Required: both `rsp_resp` = 0; read `rsp_rdata` = 0x11220044.
- Partial-strobe update:
  - Stimulus: following the previous scenario, write addr 4, data 0x00003300, wstrb 0b0010; then read addr 4.
  - Required: read `rsp_rdata` = 0x11223344; `err_count` = 0.
- Split AW/W back-pressure (bench slave):
  - Stimulus: hold `AWREADY` low 3 cycles, keep `WREADY` high.
  - Required: `WVALID` drops after 1 cycle; `AWVALID`/`AWADDR` stay stable 3 cycles; `BREADY` rises only after the AW handshake. Repeat with `WREADY` delayed instead of `AWREADY`.
- Error response (bench slave):
  - Stimulus: return `BRESP` = 2'b10, then `RRESP` = 2'b11.
  - Required: `rsp_resp` matches each; `err_count` = 2. Also preload near saturation and confirm it holds at 0xFFFF.
- Response back-pressure:
  - Stimulus: hold `rsp_ready` low 5 cycles with `cmd_valid` high.
  - Required: `rsp_valid` and `rsp_rdata` stable throughout; `cmd_ready` = 0 until the cycle after `rsp_ready`.
- Reset mid-read:
  - Stimulus: assert `rst` for 1 cycle while in RD_DATA with `RVALID` low.
  - Required: all outputs 0 next cycle; `cmd_ready` = 1 after deassert; a fresh read of addr 0 completes normally.

Source files
------------

// File: rtl/simple_axi_master.sv
// simple_axi_master: single-outstanding AXI4-Lite master.
// Turns one command on the cmd_* port into one AXI4-Lite read or write and returns the
// result on the rsp_* port. Every AXI and rsp_* output comes straight from a register.
// cmd_ready is also registered, from the next state, so it stays low while rst is held.
module simple_axi_master #(
  parameter int unsigned ADDR_WIDTH_BITS  = 3,
  parameter int unsigned DATA_WIDTH_BYTES = 4,
  localparam int unsigned DATA_WIDTH_BITS = DATA_WIDTH_BYTES * 8
) (
  input  logic                        clk,
  input  logic                        rst,
  // Command port
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [ADDR_WIDTH_BITS-1:0]  cmd_addr,
  input  logic [DATA_WIDTH_BITS-1:0]  cmd_wdata,
  input  logic [DATA_WIDTH_BYTES-1:0] cmd_wstrb,
  // Response port
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_WIDTH_BITS-1:0]  rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic [15:0]                 err_count,
  // AR channel
  output logic                        ARVALID,
  input  logic                        ARREADY,
  output logic [ADDR_WIDTH_BITS-1:0]  ARADDR,
  output logic [2:0]                  ARPROT,
  // R channel
  input  logic                        RVALID,
  output logic                        RREADY,
  input  logic [DATA_WIDTH_BITS-1:0]  RDATA,
  input  logic [1:0]                  RRESP,
  // AW channel
  output logic                        AWVALID,
  input  logic                        AWREADY,
  output logic [ADDR_WIDTH_BITS-1:0]  AWADDR,
  output logic [2:0]                  AWPROT,
  // W channel
  output logic                        WVALID,
  input  logic                        WREADY,
  output logic [DATA_WIDTH_BITS-1:0]  WDATA,
  output logic [DATA_WIDTH_BYTES-1:0] WSTRB,
  // B channel
  input  logic                        BVALID,
  output logic                        BREADY,
  input  logic [1:0]                  BRESP
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;

  logic [2:0]                  r_state;
  logic [2:0]                  w_state_d;

  logic                        r_cmd_ready;
  logic                        r_awvalid;
  logic [ADDR_WIDTH_BITS-1:0]  r_awaddr;
  logic                        r_wvalid;
  logic [DATA_WIDTH_BITS-1:0]  r_wdata;
  logic [DATA_WIDTH_BYTES-1:0] r_wstrb;
  logic                        r_bready;
  logic                        r_arvalid;
  logic [ADDR_WIDTH_BITS-1:0]  r_araddr;
  logic                        r_rready;
  logic                        r_rsp_valid;
  logic [DATA_WIDTH_BITS-1:0]  r_rsp_rdata;
  logic [1:0]                  r_rsp_resp;
  logic [15:0]                 r_err_count;

  logic                        w_cmd_fire;
  logic                        w_aw_fire;
  logic                        w_w_fire;
  logic                        w_ar_fire;
  logic                        w_b_fire;
  logic                        w_r_fire;
  logic                        w_rsp_fire;
  logic                        w_aw_pend;
  logic                        w_w_pend;
  logic                        w_enter_rsp;
  logic [1:0]                  w_new_resp;

  // Handshake decode. The ready/valid registers are only ever high in their own state, so
  // no extra state qualification is needed here.
  assign w_cmd_fire  = cmd_valid && r_cmd_ready;
  assign w_aw_fire   = r_awvalid && AWREADY;
  assign w_w_fire    = r_wvalid && WREADY;
  assign w_ar_fire   = r_arvalid && ARREADY;
  assign w_b_fire    = r_bready && BVALID;
  assign w_r_fire    = r_rready && RVALID;
  assign w_rsp_fire  = r_rsp_valid && rsp_ready;
  assign w_aw_pend   = r_awvalid && !AWREADY;
  assign w_w_pend    = r_wvalid && !WREADY;
  assign w_enter_rsp = w_b_fire || w_r_fire;
  assign w_new_resp  = w_b_fire ? BRESP : RRESP;

  // Next-state selection for the transaction sequencer.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      S_IDLE:    if (w_cmd_fire) w_state_d = cmd_write ? S_WR_REQ : S_RD_ADDR;
      // AW and W retire independently; leave once neither is still pending.
      S_WR_REQ:  if (!w_aw_pend && !w_w_pend) w_state_d = S_WR_RESP;
      S_WR_RESP: if (w_b_fire) w_state_d = S_RSP;
      S_RD_ADDR: if (w_ar_fire) w_state_d = S_RD_DATA;
      S_RD_DATA: if (w_r_fire) w_state_d = S_RSP;
      S_RSP:     if (w_rsp_fire) w_state_d = S_IDLE;
      default:   w_state_d = S_IDLE;
    endcase
  end

  // State register plus the purely state-derived ready/valid flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cmd_ready <= (w_state_d == S_IDLE);
      r_bready    <= (w_state_d == S_WR_RESP);
      r_rready    <= (w_state_d == S_RD_DATA);
      r_rsp_valid <= (w_state_d == S_RSP);
    end
  end

  // AW channel: raised on a write command, dropped (with its payload) on its own handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_awvalid <= 1'b0;
      r_awaddr  <= '0;
    end else if (w_cmd_fire && cmd_write) begin
      r_awvalid <= 1'b1;
      r_awaddr  <= cmd_addr;
    end else if (w_aw_fire) begin
      r_awvalid <= 1'b0;
      r_awaddr  <= '0;
    end
  end

  // W channel: same life cycle as AW but retires independently of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wvalid <= 1'b0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else if (w_cmd_fire && cmd_write) begin
      r_wvalid <= 1'b1;
      r_wdata  <= cmd_wdata;
      r_wstrb  <= cmd_wstrb;
    end else if (w_w_fire) begin
      r_wvalid <= 1'b0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end
  end

  // AR channel: raised on a read command, held until ARREADY.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
    end else if (w_cmd_fire && !cmd_write) begin
      r_arvalid <= 1'b1;
      r_araddr  <= cmd_addr;
    end else if (w_ar_fire) begin
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
    end
  end

  // Response payload: captured on the B or R handshake, cleared once consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
    end else if (w_enter_rsp) begin
      r_rsp_rdata <= w_r_fire ? RDATA : '0;
      r_rsp_resp  <= w_new_resp;
    end else if (w_rsp_fire) begin
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
    end
  end

  // Saturating count of non-OKAY responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= 16'd0;
    end else if (w_enter_rsp && (w_new_resp != 2'b00) && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;
  assign err_count = r_err_count;

  assign ARVALID = r_arvalid;
  assign ARADDR  = r_araddr;
  assign ARPROT  = 3'b000;
  assign RREADY  = r_rready;
  assign AWVALID = r_awvalid;
  assign AWADDR  = r_awaddr;
  assign AWPROT  = 3'b000;
  assign WVALID  = r_wvalid;
  assign WDATA   = r_wdata;
  assign WSTRB   = r_wstrb;
  assign BREADY  = r_bready;

endmodule

// File: tb/tb_simple_axi_master.sv
// tb_simple_axi_master: directed vector table plus hand sequences for simple_axi_master.
// A behavioural AXI4-Lite RAM slave with per-transaction wait and response settings is
// stepped once per cycle from the stimulus process.
module tb_simple_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [2:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] err_count;
  logic        ARVALID, ARREADY, RVALID, RREADY, AWVALID, AWREADY, WVALID, WREADY;
  logic        BVALID, BREADY;
  logic [2:0]  ARADDR, AWADDR, ARPROT, AWPROT;
  logic [31:0] RDATA, WDATA;
  logic [1:0]  RRESP, BRESP;
  logic [3:0]  WSTRB;

  always #5 clk = ~clk;

  simple_axi_master #(.ADDR_WIDTH_BITS(3), .DATA_WIDTH_BYTES(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .err_count(err_count),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
  );

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          wait_a;   // AW or AR ready delay
    int          wait_w;   // W ready delay
    int          wait_r;   // B or R valid delay
    logic [1:0]  resp_cfg;
    int          rsp_hold; // cycles rsp_ready is held low
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_lat;  // cycles from accept to rsp_valid
    logic [15:0] exp_err;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  // Slave model state
  logic [31:0] ram [8];
  int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
  logic [1:0]  bresp_cfg, rresp_cfg;
  bit          got_aw, got_w, got_ar, b_hs, r_hs;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [2:0]  s_awaddr, s_araddr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;

  // Per-cycle trace of the last transaction, indexed by cycles after accept.
  bit          lg_awv [64];
  bit          lg_wv [64];
  bit          lg_arv [64];
  bit          lg_bready [64];
  bit          lg_rready [64];
  logic [2:0]  lg_awaddr [64];
  logic [2:0]  lg_araddr [64];
  logic [31:0] lg_wdata [64];
  logic [3:0]  lg_wstrb [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic slave_reset();
    AWREADY = 0; WREADY = 0; ARREADY = 0;
    BVALID = 0; BRESP = 0; RVALID = 0; RDATA = 0; RRESP = 0;
    got_aw = 0; got_w = 0; got_ar = 0; b_hs = 0; r_hs = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    bresp_cfg = 0; rresp_cfg = 0;
    for (int i = 0; i < 8; i++) ram[i] = 32'h0;
  endtask

  // Decide slave inputs for the current cycle from the DUT outputs of this cycle.
  task automatic slave_step();
    if (b_hs) begin
      BVALID = 0; BRESP = 0; b_hs = 0; got_aw = 0; got_w = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    end
    if (r_hs) begin
      RVALID = 0; RDATA = 0; RRESP = 0; r_hs = 0; got_ar = 0; ar_cnt = 0; r_cnt = 0;
    end
    if (got_aw && got_w && !BVALID) begin
      if (b_cnt >= b_wait) begin
        BVALID = 1; BRESP = bresp_cfg;
        if (bresp_cfg == 2'b00)
          for (int i = 0; i < 4; i++)
            if (s_wstrb[i]) ram[s_awaddr][i*8 +: 8] = s_wdata[i*8 +: 8];
      end else b_cnt++;
    end
    if (BVALID && BREADY) b_hs = 1;
    if (got_ar && !RVALID) begin
      if (r_cnt >= r_wait) begin
        RVALID = 1; RDATA = ram[s_araddr]; RRESP = rresp_cfg;
      end else r_cnt++;
    end
    if (RVALID && RREADY) r_hs = 1;
    AWREADY = 0;
    if (AWVALID && !got_aw) begin
      if (aw_cnt >= aw_wait) begin AWREADY = 1; got_aw = 1; s_awaddr = AWADDR; end
      else aw_cnt++;
    end
    WREADY = 0;
    if (WVALID && !got_w) begin
      if (w_cnt >= w_wait) begin WREADY = 1; got_w = 1; s_wdata = WDATA; s_wstrb = WSTRB; end
      else w_cnt++;
    end
    ARREADY = 0;
    if (ARVALID && !got_ar) begin
      if (ar_cnt >= ar_wait) begin ARREADY = 1; got_ar = 1; s_araddr = ARADDR; end
      else ar_cnt++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    slave_step();
  endtask

  task automatic log_cycle(input int k);
    lg_awv[k] = AWVALID; lg_wv[k] = WVALID; lg_arv[k] = ARVALID;
    lg_bready[k] = BREADY; lg_rready[k] = RREADY;
    lg_awaddr[k] = AWADDR; lg_araddr[k] = ARADDR; lg_wdata[k] = WDATA; lg_wstrb[k] = WSTRB;
  endtask

  task automatic do_txn(input vec_t v, input string tag);
    int n;
    int lat;
    aw_wait = v.wait_a; ar_wait = v.wait_a; w_wait = v.wait_w;
    b_wait = v.wait_r; r_wait = v.wait_r; bresp_cfg = v.resp_cfg; rresp_cfg = v.resp_cfg;
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    cmd_wstrb = v.wstrb;
    n = 0;
    while (!cmd_ready && n < 20) begin step(); n++; end
    if (!cmd_ready) begin
      chk($sformatf("%s accept", tag), 32'(cmd_ready), 32'd1);
      cmd_valid = 0;
      return;
    end
    step();
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    lat = 1;
    log_cycle(1);
    while (!rsp_valid && lat < 40) begin step(); lat++; log_cycle(lat); end
    chk($sformatf("%s latency", tag), 32'(lat), 32'(v.exp_lat));
    if (!rsp_valid) return;
    chk($sformatf("%s rdata", tag), rsp_rdata, v.exp_rdata);
    chk($sformatf("%s resp", tag), 32'(rsp_resp), 32'(v.exp_resp));
    chk($sformatf("%s err_count", tag), 32'(err_count), 32'(v.exp_err));
    for (int i = 0; i < v.rsp_hold; i++) begin
      cmd_valid = 1; cmd_write = 0; cmd_addr = 3'd0;
      step();
      chk($sformatf("%s hold%0d rsp_valid", tag, i), 32'(rsp_valid), 32'd1);
      chk($sformatf("%s hold%0d rdata", tag, i), rsp_rdata, v.exp_rdata);
      chk($sformatf("%s hold%0d cmd_ready", tag, i), 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 0;
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk($sformatf("%s cmd_ready after rsp", tag), 32'(cmd_ready), 32'd1);
    chk($sformatf("%s rsp_valid after rsp", tag), 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[11];
    vec_t v;
    int   n;

    vecs[0]  = '{1'b1, 3'd4, 32'h11223344, 4'b1101, 0, 0, 0, 2'b00, 0, 32'h0, 2'b00, 3, 16'd0};
    vecs[1]  = '{1'b0, 3'd4, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, 32'h11220044, 2'b00, 3, 16'd0};
    vecs[2]  = '{1'b1, 3'd4, 32'h00003300, 4'b0010, 0, 0, 0, 2'b00, 0, 32'h0, 2'b00, 3, 16'd0};
    vecs[3]  = '{1'b0, 3'd4, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, 32'h11223344, 2'b00, 3, 16'd0};
    vecs[4]  = '{1'b1, 3'd0, 32'hDEADBEEF, 4'b1111, 2, 0, 1, 2'b00, 0, 32'h0, 2'b00, 6, 16'd0};
    vecs[5]  = '{1'b0, 3'd0, 32'h0, 4'h0, 1, 0, 2, 2'b00, 0, 32'hDEADBEEF, 2'b00, 6, 16'd0};
    vecs[6]  = '{1'b1, 3'd2, 32'h00000055, 4'b0001, 0, 3, 0, 2'b10, 0, 32'h0, 2'b10, 6, 16'd1};
    vecs[7]  = '{1'b0, 3'd4, 32'h0, 4'h0, 0, 0, 0, 2'b11, 5, 32'h11223344, 2'b11, 3, 16'd2};
    vecs[8]  = '{1'b0, 3'd7, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, 32'h0, 2'b00, 3, 16'd2};
    vecs[9]  = '{1'b1, 3'd3, 32'hCAFEF00D, 4'b1111, 1, 2, 0, 2'b00, 0, 32'h0, 2'b00, 5, 16'd2};
    vecs[10] = '{1'b0, 3'd3, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, 32'hCAFEF00D, 2'b00, 3, 16'd2};

    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    slave_reset();
    repeat (3) step();
    chk("reset cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset err_count", 32'(err_count), 32'd0);
    chk("reset valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY}, 32'd0);
    rst = 0;
    step();
    chk("cmd_ready after reset", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 11; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // AW held off for three cycles: W retires first, AW and its address stay put.
    v = '{1'b1, 3'd1, 32'hA5A50001, 4'b1111, 3, 0, 0, 2'b00, 0, 32'h0, 2'b00, 6, 16'd2};
    do_txn(v, "split_aw");
    chk("split_aw c1 wvalid", 32'(lg_wv[1]), 32'd1);
    chk("split_aw c2 wvalid", 32'(lg_wv[2]), 32'd0);
    chk("split_aw c2 wdata", lg_wdata[2], 32'h0);
    for (int k = 2; k <= 4; k++) begin
      chk($sformatf("split_aw c%0d awvalid", k), 32'(lg_awv[k]), 32'd1);
      chk($sformatf("split_aw c%0d awaddr", k), 32'(lg_awaddr[k]), 32'd1);
      chk($sformatf("split_aw c%0d bready", k), 32'(lg_bready[k]), 32'd0);
    end
    chk("split_aw c5 awvalid", 32'(lg_awv[5]), 32'd0);
    chk("split_aw c5 awaddr", 32'(lg_awaddr[5]), 32'd0);
    chk("split_aw c5 bready", 32'(lg_bready[5]), 32'd1);

    // W held off instead.
    v = '{1'b1, 3'd2, 32'h0000BEEF, 4'b0011, 0, 3, 0, 2'b00, 0, 32'h0, 2'b00, 6, 16'd2};
    do_txn(v, "split_w");
    chk("split_w c2 awvalid", 32'(lg_awv[2]), 32'd0);
    chk("split_w c2 awaddr", 32'(lg_awaddr[2]), 32'd0);
    for (int k = 2; k <= 4; k++) begin
      chk($sformatf("split_w c%0d wvalid", k), 32'(lg_wv[k]), 32'd1);
      chk($sformatf("split_w c%0d wdata", k), lg_wdata[k], 32'h0000BEEF);
      chk($sformatf("split_w c%0d wstrb", k), 32'(lg_wstrb[k]), 32'h3);
      chk($sformatf("split_w c%0d bready", k), 32'(lg_bready[k]), 32'd0);
    end
    chk("split_w c5 wvalid", 32'(lg_wv[5]), 32'd0);
    chk("split_w c5 bready", 32'(lg_bready[5]), 32'd1);

    // AR held off two cycles; RREADY only after the AR handshake.
    v = '{1'b0, 3'd1, 32'h0, 4'h0, 2, 0, 0, 2'b00, 0, 32'hA5A50001, 2'b00, 5, 16'd2};
    do_txn(v, "split_ar");
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("split_ar c%0d arvalid", k), 32'(lg_arv[k]), 32'd1);
      chk($sformatf("split_ar c%0d araddr", k), 32'(lg_araddr[k]), 32'd1);
      chk($sformatf("split_ar c%0d rready", k), 32'(lg_rready[k]), 32'd0);
    end
    chk("split_ar c4 arvalid", 32'(lg_arv[4]), 32'd0);
    chk("split_ar c4 araddr", 32'(lg_araddr[4]), 32'd0);
    chk("split_ar c4 rready", 32'(lg_rready[4]), 32'd1);
    v = '{1'b0, 3'd2, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, 32'h0000BEEF, 2'b00, 3, 16'd2};
    do_txn(v, "read_split_w");

    // Reset while waiting in the read-data phase.
    ar_wait = 0; r_wait = 20; rresp_cfg = 0;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 3'd0;
    n = 0;
    while (!cmd_ready && n < 20) begin step(); n++; end
    step();
    cmd_valid = 0;
    n = 0;
    while (!RREADY && n < 20) begin step(); n++; end
    chk("midrd rready before reset", 32'(RREADY), 32'd1);
    rst = 1;
    step();
    chk("midrd cmd_ready", 32'(cmd_ready), 32'd0);
    chk("midrd rsp", {rsp_valid, rsp_resp}, 32'd0);
    chk("midrd rsp_rdata", rsp_rdata, 32'd0);
    chk("midrd err_count", 32'(err_count), 32'd0);
    chk("midrd valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY}, 32'd0);
    chk("midrd addrs", {ARADDR, AWADDR, ARPROT, AWPROT, WSTRB}, 32'd0);
    chk("midrd wdata", WDATA, 32'd0);
    rst = 0;
    slave_reset();
    step();
    chk("midrd cmd_ready after reset", 32'(cmd_ready), 32'd1);
    v = '{1'b0, 3'd0, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, 32'h0, 2'b00, 3, 16'd0};
    do_txn(v, "midrd fresh read");

    // Saturation: start the counter one below the limit.
    force dut.r_err_count = 16'hFFFE;
    step();
    release dut.r_err_count;
    step();
    v = '{1'b1, 3'd5, 32'h00000001, 4'b1111, 0, 0, 0, 2'b10, 0, 32'h0, 2'b10, 3, 16'hFFFF};
    do_txn(v, "sat bresp");
    v = '{1'b0, 3'd5, 32'h0, 4'h0, 0, 0, 0, 2'b11, 0, 32'h0, 2'b11, 3, 16'hFFFF};
    do_txn(v, "sat rresp");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
